eth_rx_fcs_checker: RTL and testbench



---
 rtl/eth_rx_fcs_checker.sv | 142 ++++++++++++++
 tb/tb_eth_rx_fcs_checker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_fcs_checker.sv
// Ethernet RX FCS checker: CRC-32 check, FCS strip and length check ahead of the RX async FIFO.
// Define ETH_RX_FCS_STATS_EN to add the saturating frame statistics counters.
module eth_rx_fcs_checker #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 aclk,
  input  logic                 sreset,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 s_axis_trdy,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_trdy
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_good_frames,
  output logic [CNT_WIDTH-1:0] stat_crc_err,
  output logic [CNT_WIDTH-1:0] stat_len_err,
  output logic [CNT_WIDTH-1:0] stat_phy_err
`endif
);

  localparam logic [31:0]          CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]          CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0]          CRC_POLY    = 32'hEDB8_8320;
  localparam logic [CNT_WIDTH-1:0] LEN_SAT     = '1;
  localparam logic [CNT_WIDTH-1:0] MIN_LEN     = CNT_WIDTH'(MIN_FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] MAX_LEN     = CNT_WIDTH'(MAX_FRAME_LEN);

  logic [3:0][7:0]      dly;
  logic [2:0]           fill;
  logic [CNT_WIDTH-1:0] len;
  logic [31:0]          crc;
  logic                 err;

  logic                 accept;
  logic                 full;
  logic                 runt;
  logic                 emit;
  logic [31:0]          crc_nxt;
  logic [CNT_WIDTH-1:0] len_nxt;
  logic                 crc_bad;
  logic                 len_bad;
  logic                 phy_bad;
  logic                 frame_bad;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign s_axis_trdy = !sreset && (!m_axis_tvalid || m_axis_trdy);
  assign accept      = s_axis_tvalid && s_axis_trdy;
  assign full        = (fill == 3'd4);
  assign runt        = s_axis_tlast && !full;
  assign emit        = accept && (full || s_axis_tlast);

  // Decisions on the last byte use the post-update CRC and length so tlast carries no extra cycle.
  assign crc_nxt   = crc_step(crc, s_axis_tdata);
  assign len_nxt   = (len == LEN_SAT) ? len : len + 1'b1;
  assign crc_bad   = (crc_nxt != CRC_RESIDUE);
  assign len_bad   = runt || (len_nxt < MIN_LEN) || (len_nxt > MAX_LEN);
  assign phy_bad   = err || s_axis_tuser;
  assign frame_bad = crc_bad || len_bad || phy_bad;

  always_ff @(posedge aclk) begin
    if (sreset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= 8'h00;
      dly           <= '0;
      fill          <= 3'd0;
      len           <= '0;
      crc           <= CRC_INIT;
      err           <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_trdy) begin
        m_axis_tvalid <= 1'b0;
      end
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= runt ? 8'h00 : dly[3];
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tuser  <= s_axis_tlast && frame_bad;
      end
      if (accept) begin
        if (s_axis_tlast) begin
          // Remaining delay-line bytes are FCS; restart cleanly for a back-to-back frame.
          fill <= 3'd0;
          len  <= '0;
          crc  <= CRC_INIT;
          err  <= 1'b0;
        end else begin
          dly  <= {dly[2:0], s_axis_tdata};
          len  <= len_nxt;
          crc  <= crc_nxt;
          err  <= phy_bad;
          if (!full) begin
            fill <= fill + 3'd1;
          end
        end
      end
    end
  end

`ifdef ETH_RX_FCS_STATS_EN
  logic stat_tick;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == LEN_SAT) ? v : v + 1'b1;
  endfunction

  assign stat_tick = emit && s_axis_tlast;

  // A runt is counted only as a length error; its CRC over a partial frame is meaningless.
  always_ff @(posedge aclk) begin
    if (sreset) begin
      stat_good_frames <= '0;
      stat_crc_err     <= '0;
      stat_len_err     <= '0;
      stat_phy_err     <= '0;
    end else if (stat_tick) begin
      if (!frame_bad)        stat_good_frames <= sat_inc(stat_good_frames);
      if (!runt && crc_bad)  stat_crc_err     <= sat_inc(stat_crc_err);
      if (len_bad)           stat_len_err     <= sat_inc(stat_len_err);
      if (phy_bad)           stat_phy_err     <= sat_inc(stat_phy_err);
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_checker.sv
// Directed bench for eth_rx_fcs_checker: good/bad CRC, runts, length limits, stalls, mid-frame reset.
// Checks the statistics counters when ETH_RX_FCS_STATS_EN is defined.
module tb_eth_rx_fcs_checker;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          sreset = 1'b1;
  logic [7:0]    s_tdata = 8'h00;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_axis_trdy;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          m_trdy = 1'b1;
`ifdef ETH_RX_FCS_STATS_EN
  logic [CW-1:0] stat_good_frames, stat_crc_err, stat_len_err, stat_phy_err;
`endif

  always #5 aclk = ~aclk;

  eth_rx_fcs_checker #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .CNT_WIDTH(CW)) dut (
    .aclk          (aclk),
    .sreset        (sreset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_trdy   (s_axis_trdy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_trdy   (m_trdy)
`ifdef ETH_RX_FCS_STATS_EN
    ,
    .stat_good_frames (stat_good_frames),
    .stat_crc_err     (stat_crc_err),
    .stat_len_err     (stat_len_err),
    .stat_phy_err     (stat_phy_err)
`endif
  );

  int         pass_cnt = 0;
  int         check_cnt = 0;
  int         fail_cnt = 0;
  logic [7:0] fbuf [0:1599];
  int         flen = 0;
  int         phy_idx = -1;
  bit         rnd_mode = 1'b0;
  logic [7:0] exp_data [$];
  logic       exp_last [$];
  int         exp_base = 0;
  logic [7:0] q_data [$];
  logic       q_last [$];
  logic       q_user [$];
  int         q_base = 0;
  int         stall_err = 0;
  logic       held = 1'b0;
  logic [9:0] hv = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Builds payload + FCS (LSB first) into fbuf and appends the expected output beats.
  task automatic gen_frame(input int len, input int seed, input bit corrupt);
    logic [31:0] c;
    flen = len;
    c = 32'hFFFFFFFF;
    if (len < 5) begin
      for (int i = 0; i < len; i++) fbuf[i] = 8'(seed * 31 + i);
      exp_data.push_back(8'h00);
      exp_last.push_back(1'b1);
    end else begin
      for (int i = 0; i < len - 4; i++) begin
        fbuf[i] = 8'((i * 7 + seed * 13 + 1) ^ (i >> 3));
        c = crc_step(c, fbuf[i]);
      end
      c = ~c;
      fbuf[len-4] = c[7:0];
      fbuf[len-3] = c[15:8];
      fbuf[len-2] = c[23:16];
      fbuf[len-1] = c[31:24];
      if (corrupt) fbuf[10] = fbuf[10] ^ 8'h01;
      for (int i = 0; i < len - 4; i++) begin
        exp_data.push_back(fbuf[i]);
        exp_last.push_back(i == len - 5);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following the last accept.
  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      bit acc;
      int tries;
      s_tdata  = fbuf[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == flen - 1);
      s_tuser  = (i == phy_idx);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
        m_trdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        acc = s_axis_trdy;
        @(negedge aclk);
        tries++;
      end
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      m_trdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_axis_tvalid === 1'b0) done = 1'b1;
      @(negedge aclk);
    end
    if (!done) chk("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_beats(input string tag, input bit user_exp);
    int n_got, n_exp, bad, ubad;
    n_got = q_data.size() - q_base;
    n_exp = exp_data.size() - exp_base;
    bad = 0;
    ubad = 0;
    chk({tag, "_beats"}, 32'(n_got), 32'(n_exp));
    if (n_got == n_exp) begin
      for (int b = 0; b < n_got; b++) begin
        if (q_data[q_base+b] !== exp_data[exp_base+b] || q_last[q_base+b] !== exp_last[exp_base+b]) bad++;
        if (q_last[q_base+b] && q_user[q_base+b] !== user_exp) ubad++;
      end
    end else begin
      bad = 1;
    end
    chk({tag, "_data"}, 32'(bad), 32'd0);
    chk({tag, "_tuser"}, 32'(ubad), 32'd0);
    q_base = q_data.size();
    exp_base = exp_data.size();
  endtask

  // Output monitor: records every handshake and flags any change while stalled.
  always @(negedge aclk) begin
    #2;
    if (sreset) begin
      held = 1'b0;
    end else begin
      if (held && (m_axis_tvalid !== 1'b1 || {m_axis_tdata, m_axis_tlast, m_axis_tuser} !== hv))
        stall_err++;
      if (m_axis_tvalid === 1'b1 && m_trdy) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_user.push_back(m_axis_tuser);
      end
      held = m_axis_tvalid && !m_trdy;
      hv = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tuser",  32'(m_axis_tuser),  32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_trdy",   32'(s_axis_trdy),   32'd0);
    sreset = 1'b0;
    @(negedge aclk);

    gen_frame(64, 1, 1'b0);
    send_range(0, 4);
    chk("lat_after4_valid", 32'(m_axis_tvalid), 32'd0);
    send_range(4, 5);
    chk("lat_after5_valid", 32'(m_axis_tvalid), 32'd1);
    chk("lat_after5_data",  32'(m_axis_tdata),  32'(fbuf[0]));
    send_range(5, 64);
    drain();
    check_beats("good64", 1'b0);

    gen_frame(64, 2, 1'b1);  send_range(0, flen); drain(); check_beats("crc_bad", 1'b1);
    gen_frame(3, 3, 1'b0);   send_range(0, flen); drain(); check_beats("runt3", 1'b1);
    gen_frame(63, 4, 1'b0);  send_range(0, flen); drain(); check_beats("runt63", 1'b1);
    gen_frame(64, 5, 1'b0);
    phy_idx = 30;
    send_range(0, flen);
    phy_idx = -1;
    drain();
    check_beats("phy_err", 1'b1);
    gen_frame(1519, 6, 1'b0); send_range(0, flen); drain(); check_beats("over1519", 1'b1);
    gen_frame(1518, 7, 1'b0); send_range(0, flen); drain(); check_beats("max1518", 1'b0);

    rnd_mode = 1'b1;
    gen_frame(64, 8, 1'b0);  send_range(0, flen);
    gen_frame(100, 9, 1'b0); send_range(0, flen);
    gen_frame(64, 10, 1'b0); send_range(0, flen);
    drain();
    rnd_mode = 1'b0;
    check_beats("rand3", 1'b0);
    chk("stall_stable", 32'(stall_err), 32'd0);

    gen_frame(64, 11, 1'b0);
    send_range(0, 20);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_trdy = 1'b0;
    @(negedge aclk);
    chk("rst_mid_pending", 32'(m_axis_tvalid), 32'd1);
    sreset = 1'b1;
    @(negedge aclk);
    sreset = 1'b0;
    chk("rst_mid_valid", 32'(m_axis_tvalid), 32'd0);
    m_trdy = 1'b1;
    @(negedge aclk);
    q_base = q_data.size();
    exp_base = exp_data.size();
    gen_frame(64, 12, 1'b0); send_range(0, flen); drain(); check_beats("after_rst", 1'b0);

`ifdef ETH_RX_FCS_STATS_EN
    sreset = 1'b1;
    @(negedge aclk);
    sreset = 1'b0;
    @(negedge aclk);
    gen_frame(64, 13, 1'b0);   send_range(0, flen);
    gen_frame(64, 14, 1'b1);   send_range(0, flen);
    gen_frame(63, 15, 1'b0);   send_range(0, flen);
    gen_frame(1519, 16, 1'b0); send_range(0, flen);
    drain();
    q_base = q_data.size();
    exp_base = exp_data.size();
    chk("stat_good", 32'(stat_good_frames), 32'd1);
    chk("stat_crc",  32'(stat_crc_err),     32'd1);
    chk("stat_len",  32'(stat_len_err),     32'd2);
    chk("stat_phy",  32'(stat_phy_err),     32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
